cu_irq_ctrl: RTL and testbench

CU_IRQ_CTRL -- requirements
Module: cu_irq_ctrl

---
 rtl/cu_irq_ctrl_if.sv | 21 ++
 rtl/cu_irq_ctrl.sv | 122 ++++++++++++
 tb/tb_cu_irq_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_irq_ctrl_if.sv
// Request/acknowledge link between the interrupt controller (master) and the core (slave).
interface cu_irq_ctrl_if;
    logic       irq_o;
    logic [4:0] irq_id_o;
    logic       irq_ack_i;
    logic [4:0] irq_ack_id_i;

    modport master (
        output irq_o,
        output irq_id_o,
        input  irq_ack_i,
        input  irq_ack_id_i
    );

    modport slave (
        input  irq_o,
        input  irq_id_o,
        output irq_ack_i,
        output irq_ack_id_i
    );
endinterface

// File: rtl/cu_irq_ctrl.sv
// Interrupt controller: latches edge/level sources, picks one by fixed or round-robin priority,
// holds it on the core request link until acknowledged, then forces a one-cycle gap.
module cu_irq_ctrl #(
    parameter int                 NUM_SRC  = 4,
    parameter logic [4:0]         BASE_ID  = 5'd0,
    parameter logic [NUM_SRC-1:0] SRC_EDGE = '1,
    parameter bit                 RR_EN    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] irq_en_i,
    cu_irq_ctrl_if.master      irq_bus,
    output logic [NUM_SRC-1:0] pending_o,
    output logic               ack_err_o
);

    localparam int SELW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] srcPrev_q;
    logic               armed_q;
    logic [SELW-1:0]    sel_q, sel_d;
    logic [SELW-1:0]    lastGrant_q, lastGrant_d;
    logic [4:0]         id_q, id_d;
    logic               ackErr_q, ackErr_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] risen;
    logic [NUM_SRC-1:0] clrMask;
    logic [SELW-1:0]    winner;
    logic [SELW-1:0]    searchIdx;
    logic               winnerValid;
    logic               ackAccept;

    // armed_q masks the first cycle after reset so a source held high is not seen as an edge
    assign risen     = irq_src_i & ~srcPrev_q & {NUM_SRC{armed_q}};
    assign eligible  = pending_q & irq_en_i;
    assign ackAccept = (state_q == REQ) && irq_bus.irq_ack_i && (irq_bus.irq_ack_id_i == id_q);

    always_comb begin
        winner      = '0;
        winnerValid = 1'b0;
        searchIdx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (RR_EN) searchIdx = SELW'((int'(lastGrant_q) + 1 + i) % NUM_SRC);
            else       searchIdx = SELW'(i);
            if (!winnerValid && eligible[searchIdx]) begin
                winnerValid = 1'b1;
                winner      = searchIdx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        id_d        = id_q;
        lastGrant_d = lastGrant_q;
        clrMask     = '0;
        ackErr_d    = ackErr_q | (irq_bus.irq_ack_i & ~ackAccept);

        unique case (state_q)
            IDLE: begin
                if (winnerValid) begin
                    state_d = REQ;
                    sel_d   = winner;
                    id_d    = BASE_ID + 5'(winner);
                end
            end
            REQ: begin
                if (ackAccept) begin
                    state_d          = GAP;
                    lastGrant_d      = sel_q;
                    clrMask[sel_q]   = 1'b1;
                end else if (!eligible[sel_q]) begin
                    state_d = IDLE;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new edge beats a same-cycle clear; level sources just follow their input
        pending_d = ((risen | (pending_q & ~clrMask)) & SRC_EDGE) | (irq_src_i & ~SRC_EDGE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            srcPrev_q   <= '0;
            armed_q     <= 1'b0;
            sel_q       <= '0;
            lastGrant_q <= SELW'(NUM_SRC - 1);
            id_q        <= '0;
            ackErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            srcPrev_q   <= irq_src_i;
            armed_q     <= 1'b1;
            sel_q       <= sel_d;
            lastGrant_q <= lastGrant_d;
            id_q        <= id_d;
            ackErr_q    <= ackErr_d;
        end
    end

    assign irq_bus.irq_o    = (state_q == REQ);
    assign irq_bus.irq_id_o = id_q;
    assign pending_o        = pending_q;
    assign ack_err_o        = ackErr_q;

endmodule

// File: tb/tb_cu_irq_ctrl.sv
// Scoreboard bench: dutA uses fixed priority with source 0 level, dutB uses round-robin.
module tb_cu_irq_ctrl;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] srcA, enA, srcB, enB;
    logic [3:0] pendA, pendB;
    logic       errA, errB;

    cu_irq_ctrl_if ifA ();
    cu_irq_ctrl_if ifB ();

    cu_irq_ctrl #(.NUM_SRC(4), .BASE_ID(5'd16), .SRC_EDGE(4'b1110), .RR_EN(1'b0)) dutA (
        .clk(clk), .rst_n(rst_n), .irq_src_i(srcA), .irq_en_i(enA),
        .irq_bus(ifA.master), .pending_o(pendA), .ack_err_o(errA)
    );

    cu_irq_ctrl #(.NUM_SRC(4), .BASE_ID(5'd16), .SRC_EDGE(4'b1111), .RR_EN(1'b1)) dutB (
        .clk(clk), .rst_n(rst_n), .irq_src_i(srcB), .irq_en_i(enB),
        .irq_bus(ifB.master), .pending_o(pendB), .ack_err_o(errB)
    );

    typedef struct {
        logic [4:0] id;
        int         cyc;
    } exp_t;

    exp_t expA[$];
    exp_t expB[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prevA = 1'b0;
    logic prevB = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit toB, input logic [3:0] src, input logic [3:0] en,
                                 input logic ack, input logic [4:0] ackId);
        if (toB) begin
            srcB = src; enB = en; ifB.irq_ack_i = ack; ifB.irq_ack_id_i = ackId;
        end else begin
            srcA = src; enA = en; ifA.irq_ack_i = ack; ifA.irq_ack_id_i = ackId;
        end
    endtask

    task automatic pushExp(input bit toB, input logic [4:0] id, input int c);
        exp_t e;
        e.id  = id;
        e.cyc = c;
        if (toB) expB.push_back(e);
        else     expA.push_back(e);
    endtask

    // Each rising edge of irq_o is one granted request; compare it with the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (ifA.irq_o && !prevA) begin
            if (expA.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL A_unexpected_req: got id %0d, expected no request (cycle %0d)", ifA.irq_id_o, cyc);
            end else begin
                e = expA.pop_front();
                checkOutput("A_grant_id", 32'(ifA.irq_id_o), 32'(e.id));
                checkOutput("A_grant_cycle", cyc, e.cyc);
            end
        end
        if (ifB.irq_o && !prevB) begin
            if (expB.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL B_unexpected_req: got id %0d, expected no request (cycle %0d)", ifB.irq_id_o, cyc);
            end else begin
                e = expB.pop_front();
                checkOutput("B_grant_id", 32'(ifB.irq_id_o), 32'(e.id));
                checkOutput("B_grant_cycle", cyc, e.cyc);
            end
        end
        prevA <= ifA.irq_o;
        prevB <= ifB.irq_o;
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected run to complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 5'd0);
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 5'd0);

        waitCycle(3);
        checkOutput("A_rst_irq", 32'(ifA.irq_o), 0);
        checkOutput("A_rst_id", 32'(ifA.irq_id_o), 0);
        checkOutput("A_rst_pending", 32'(pendA), 0);
        checkOutput("A_rst_err", 32'(errA), 0);
        checkOutput("B_rst_irq", 32'(ifB.irq_o), 0);
        checkOutput("B_rst_pending", 32'(pendB), 0);
        rst_n = 1'b1;

        // single edge on source 2: request two cycles later, ack clears it
        waitCycle(10); applyStimulus(1'b0, 4'b0100, 4'hF, 1'b0, 5'd0); pushExp(1'b0, 5'd18, 12);
        waitCycle(11); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        checkOutput("A_pending_edge", 32'(pendA), 'h4);
        checkOutput("A_irq_latency_low", 32'(ifA.irq_o), 0);
        waitCycle(13);
        checkOutput("A_irq_held", 32'(ifA.irq_o), 1);
        checkOutput("A_id_held", 32'(ifA.irq_id_o), 18);
        waitCycle(15); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 5'd18);
        waitCycle(16); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        checkOutput("A_gap_irq", 32'(ifA.irq_o), 0);
        checkOutput("A_ack_clears", 32'(pendA), 0);
        checkOutput("A_no_err", 32'(errA), 0);

        // simultaneous edges on 3 and 1: lowest index first, then 3 after the gap
        waitCycle(20); applyStimulus(1'b0, 4'b1010, 4'hF, 1'b0, 5'd0); pushExp(1'b0, 5'd17, 22);
        waitCycle(21); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        waitCycle(23); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 5'd17);
        waitCycle(24); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        checkOutput("A_prio_gap", 32'(ifA.irq_o), 0);
        checkOutput("A_prio_pending", 32'(pendA), 'h8);
        pushExp(1'b0, 5'd19, 26);
        waitCycle(25);
        checkOutput("A_prio_idle", 32'(ifA.irq_o), 0);
        waitCycle(27); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 5'd19);
        waitCycle(28); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        checkOutput("A_prio_done", 32'(pendA), 0);

        // disabled source keeps pending, is withdrawn from REQ when disabled, re-requests when enabled
        waitCycle(30); applyStimulus(1'b0, 4'b1000, 4'b0111, 1'b0, 5'd0);
        waitCycle(31); applyStimulus(1'b0, 4'b0000, 4'b0111, 1'b0, 5'd0);
        checkOutput("A_dis_pending", 32'(pendA), 'h8);
        waitCycle(33);
        checkOutput("A_dis_no_irq", 32'(ifA.irq_o), 0);
        waitCycle(34); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0); pushExp(1'b0, 5'd19, 35);
        waitCycle(36);
        checkOutput("A_en_id", 32'(ifA.irq_id_o), 19);
        waitCycle(37); applyStimulus(1'b0, 4'b0000, 4'b0111, 1'b0, 5'd0);
        waitCycle(38);
        checkOutput("A_withdraw_irq", 32'(ifA.irq_o), 0);
        checkOutput("A_withdraw_pending", 32'(pendA), 'h8);
        waitCycle(39); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0); pushExp(1'b0, 5'd19, 40);
        waitCycle(42); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 5'd19);
        waitCycle(43); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        checkOutput("A_reen_cleared", 32'(pendA), 0);

        // wrong-ID ack is ignored and sticky; a new higher-priority edge does not preempt
        waitCycle(50); applyStimulus(1'b0, 4'b0100, 4'hF, 1'b0, 5'd0); pushExp(1'b0, 5'd18, 52);
        waitCycle(51); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        waitCycle(53); applyStimulus(1'b0, 4'b0010, 4'hF, 1'b1, 5'd7);
        waitCycle(54); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        checkOutput("A_badack_irq", 32'(ifA.irq_o), 1);
        checkOutput("A_nopreempt_id", 32'(ifA.irq_id_o), 18);
        checkOutput("A_badack_err", 32'(errA), 1);
        checkOutput("A_badack_pending", 32'(pendA), 'h6);
        waitCycle(55); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 5'd18);
        waitCycle(56); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        checkOutput("A_goodack_pending", 32'(pendA), 'h2);
        pushExp(1'b0, 5'd17, 58);
        waitCycle(58);
        checkOutput("A_err_sticky", 32'(errA), 1);
        waitCycle(59); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 5'd17);

        // reset in REQ with the source held high: no phantom edge after release
        waitCycle(60); applyStimulus(1'b0, 4'b0100, 4'hF, 1'b0, 5'd0); pushExp(1'b0, 5'd18, 62);
        waitCycle(63);
        checkOutput("A_pre_rst_irq", 32'(ifA.irq_o), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("A_async_rst_irq", 32'(ifA.irq_o), 0);
        checkOutput("A_rst_clears_err", 32'(errA), 0);
        checkOutput("A_rst_clears_pending", 32'(pendA), 0);
        waitCycle(66); rst_n = 1'b1;
        waitCycle(72);
        checkOutput("A_held_no_edge", 32'(pendA), 0);
        checkOutput("A_held_no_irq", 32'(ifA.irq_o), 0);
        waitCycle(73); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        waitCycle(74); applyStimulus(1'b0, 4'b0100, 4'hF, 1'b0, 5'd0); pushExp(1'b0, 5'd18, 76);
        waitCycle(75); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        waitCycle(77); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 5'd18);
        waitCycle(78); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        checkOutput("A_rearm_cleared", 32'(pendA), 0);

        // level source 0 withdrawn before ack
        waitCycle(80); applyStimulus(1'b0, 4'b0001, 4'hF, 1'b0, 5'd0); pushExp(1'b0, 5'd16, 82);
        waitCycle(81);
        checkOutput("A_level_pending", 32'(pendA), 'h1);
        waitCycle(84); applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 5'd0);
        waitCycle(85);
        checkOutput("A_level_still_req", 32'(ifA.irq_o), 1);
        waitCycle(86);
        checkOutput("A_level_dropped", 32'(ifA.irq_o), 0);
        checkOutput("A_level_no_err", 32'(errA), 0);
        checkOutput("A_level_pending_low", 32'(pendA), 0);

        // round-robin on dutB; each ack re-triggers the acked source in the same cycle
        waitCycle(90); rst_n = 1'b0;
        waitCycle(92); rst_n = 1'b1;
        waitCycle(95); applyStimulus(1'b1, 4'hF, 4'hF, 1'b0, 5'd0);
        for (int k = 0; k < 5; k++) pushExp(1'b1, 5'(16 + (k % 4)), 97 + 4 * k);
        waitCycle(96); applyStimulus(1'b1, 4'h0, 4'hF, 1'b0, 5'd0);
        checkOutput("B_all_pending", 32'(pendB), 'hF);
        for (int k = 0; k < 5; k++) begin
            waitCycle(98 + 4 * k);
            applyStimulus(1'b1, 4'(1 << (k % 4)), 4'hF, 1'b1, 5'(16 + (k % 4)));
            waitCycle(99 + 4 * k);
            applyStimulus(1'b1, 4'h0, (k == 4) ? 4'h0 : 4'hF, 1'b0, 5'd0);
        end
        waitCycle(120);
        checkOutput("B_set_wins_pending", 32'(pendB), 'hF);
        checkOutput("B_no_err", 32'(errB), 0);
        checkOutput("B_idle_irq", 32'(ifB.irq_o), 0);
        checkOutput("A_queue_drained", expA.size(), 0);
        checkOutput("B_queue_drained", expB.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
